// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard control for the 5-stage integer pipeline.
// Shadows the destination info of instructions in EX, MEM and WB to pick the
// EX operand sources. It also detects load-use hazards, squashes IF/ID on a
// taken branch, and counts stall and flush cycles.
module forwarding_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  // ID/EX shadow
  logic                  ex_valid_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q;
  logic [REG_ADDR_W-1:0] ex_rs2_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  ex_regwrite_q;
  logic                  ex_memread_q;

  // EX/MEM shadow. The load flag is not carried here: a load that reaches MEM
  // cannot have its consumer in EX, because the load-use stall inserts a bubble.
  logic                  mem_valid_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  mem_regwrite_q;

  // MEM/WB shadow
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  wb_regwrite_q;

  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] flush_count_q;

  logic mem_fwd_ok;
  logic wb_fwd_ok;
  logic load_use;
  logic ex_bubble;

  // Operand select from shadow state only; EX/MEM beats MEM/WB, x0 never forwards
  always_comb begin
    forward_a  = FwdReg;
    forward_b  = FwdReg;
    mem_fwd_ok = mem_valid_q && mem_regwrite_q && (mem_rd_q != '0);
    wb_fwd_ok  = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0);
    if (ex_valid_q) begin
      if (mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
        forward_a = FwdMem;
      end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
        forward_a = FwdWb;
      end
      if (mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
        forward_b = FwdMem;
      end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
        forward_b = FwdWb;
      end
    end
  end

  // Load-use detection; a taken branch wins and reset masks both controls
  always_comb begin
    load_use  = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    stall     = !rst && load_use && !branch_taken;
    flush     = !rst && branch_taken;
    ex_bubble = stall || flush || !id_valid;
  end

  // Shadow pipeline advance and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      mem_valid_q    <= ex_valid_q;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      wb_valid_q     <= mem_valid_q;
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      if (ex_bubble) begin
        ex_valid_q    <= 1'b0;
        ex_rs1_q      <= '0;
        ex_rs2_q      <= '0;
        ex_rd_q       <= '0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
      end else begin
        ex_valid_q    <= 1'b1;
        ex_rs1_q      <= id_rs1;
        ex_rs2_q      <= id_rs2;
        ex_rd_q       <= id_rd;
        ex_regwrite_q <= id_regwrite;
        ex_memread_q  <= id_memread;
      end
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
